// File: rtl/tc_pkg.sv
// Tile geometry defaults and index helpers shared by the tensor-core tile blocks.
package tc_pkg;

   localparam int DEF_TILE_M = 4;
   localparam int DEF_TILE_K = 8;
   localparam int DEF_TILE_N = 4;

   function automatic int CLOG2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Product lane index of term k contributing to C element (m,n).
   function automatic int idx(input int m, input int k, input int n,
                              input int tile_k, input int tile_n);
      return (m * tile_n + n) * tile_k + k;
   endfunction

   function automatic int OUT_IDX(input int m, input int n, input int tile_n);
      return m * tile_n + n;
   endfunction

endpackage

// File: rtl/product_reduce_accumulator_adder_tree.sv
// Pipelined binary adder tree: N_IN operands reduced to one sum over CLOG2(N_IN) registered levels.
module adder_tree
   import tc_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int DW   = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic [N_IN*DW-1:0] in_vec,
   input  logic               in_valid,
   input  logic               in_last,
   output logic [DW-1:0]      sum,
   output logic               out_valid,
   output logic               out_last
);

   localparam int LVLS = CLOG2(N_IN);
   localparam int HALF = N_IN / 2;

   // Nodes stored level after level: level 0 at [0, HALF), each later node i
   // adds the node pair starting at 2*(i-HALF); the root is the last entry.
   logic [DW-1:0]   node_q [N_IN-1];
   logic [DW-1:0]   node_d [N_IN-1];
   logic [LVLS-1:0] vld_q;
   logic [LVLS-1:0] last_q;

   always_comb begin
      for (int i = 0; i < N_IN - 1; i++) node_d[i] = node_q[i];
      for (int i = 0; i < HALF; i++) begin
         node_d[i] = in_vec[(2*i)*DW +: DW] + in_vec[(2*i+1)*DW +: DW];
      end
      for (int i = HALF; i < N_IN - 1; i++) begin
         node_d[i] = node_q[2*(i-HALF)] + node_q[2*(i-HALF)+1];
      end
   end

   always_ff @(posedge clk) begin
      if (!hold) node_q <= node_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         last_q <= '0;
      end else if (!hold) begin
         vld_q[0]  <= in_valid;
         last_q[0] <= in_last;
         for (int l = 1; l < LVLS; l++) begin
            vld_q[l]  <= vld_q[l-1];
            last_q[l] <= last_q[l-1];
         end
      end
   end

   assign sum       = node_q[N_IN-2];
   assign out_valid = vld_q[LVLS-1];
   assign out_last  = last_q[LVLS-1];

endmodule

// File: rtl/product_reduce_accumulator.sv
// Reduces TILE_K lane products per C element, accumulates over k-beats and
// presents the finished C tile through a single valid/ready output buffer.
module product_reduce_accumulator
   import tc_pkg::*;
#(
   parameter int TILE_M = DEF_TILE_M,
   parameter int TILE_K = DEF_TILE_K,
   parameter int TILE_N = DEF_TILE_N,
   parameter int DW_IN  = 8,
   parameter int DW_ACC = 20,
   parameter int SIGNED = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [TILE_M*TILE_K*TILE_N*DW_IN-1:0] in_prod,
   input  logic                                in_valid,
   input  logic                                in_last,
   output logic                                in_ready,
   output logic [TILE_M*TILE_N*DW_ACC-1:0]     out_c,
   output logic [7:0]                          out_beats,
   output logic                                out_valid,
   input  logic                                out_ready
);

   localparam int N_UNIT = TILE_M * TILE_K * TILE_N;
   localparam int N_OUT  = TILE_M * TILE_N;

   function automatic logic [DW_ACC-1:0] ext(input logic [DW_IN-1:0] x);
      logic signed [DW_IN-1:0] xs;
      xs = x;
      if (SIGNED != 0) return DW_ACC'(xs);
      return DW_ACC'(x);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] b);
      return (b == 8'hFF) ? 8'hFF : b + 8'd1;
   endfunction

   logic                          stall;
   logic [N_UNIT*DW_IN-1:0]       prod_q;
   logic                          in_vld_q;
   logic                          in_last_q;
   logic [N_UNIT*DW_ACC-1:0]      ext_vec;
   logic [DW_ACC-1:0]             tree_sum [N_OUT];
   logic                          tree_vld;
   logic                          tree_last;
   logic [DW_ACC-1:0]             sum_new  [N_OUT];
   logic [DW_ACC-1:0]             acc_q    [N_OUT];
   logic [DW_ACC-1:0]             acc_d    [N_OUT];
   logic [7:0]                    beats_q, beats_d, beats_new;
   logic [7:0]                    out_beats_q, out_beats_d;
   logic                          first_q, first_d;
   logic                          out_valid_q, out_valid_d;
   logic [N_OUT*DW_ACC-1:0]       out_c_q, out_c_d;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall & ~reset;

   // Input capture stage
   always_ff @(posedge clk) begin
      if (reset) begin
         in_vld_q  <= 1'b0;
         in_last_q <= 1'b0;
      end else if (!stall) begin
         in_vld_q  <= in_valid;
         in_last_q <= in_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) prod_q <= in_prod;
   end

   always_comb begin
      ext_vec = '0;
      for (int m = 0; m < TILE_M; m++) begin
         for (int n = 0; n < TILE_N; n++) begin
            for (int k = 0; k < TILE_K; k++) begin
               ext_vec[(OUT_IDX(m, n, TILE_N)*TILE_K + k)*DW_ACC +: DW_ACC] =
                  ext(prod_q[idx(m, k, n, TILE_K, TILE_N)*DW_IN +: DW_IN]);
            end
         end
      end
   end

   // Reduction stages; every copy runs in lockstep so copy 0 carries the control.
   for (genvar g = 0; g < N_OUT; g++) begin : g_tree
      if (g == 0) begin : g_ctl
         adder_tree #(.N_IN(TILE_K), .DW(DW_ACC)) u_tree (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall),
            .in_vec    (ext_vec[g*TILE_K*DW_ACC +: TILE_K*DW_ACC]),
            .in_valid  (in_vld_q),
            .in_last   (in_last_q),
            .sum       (tree_sum[g]),
            .out_valid (tree_vld),
            .out_last  (tree_last)
         );
      end else begin : g_data
         adder_tree #(.N_IN(TILE_K), .DW(DW_ACC)) u_tree (
            .clk       (clk),
            .reset     (reset),
            .hold      (stall),
            .in_vec    (ext_vec[g*TILE_K*DW_ACC +: TILE_K*DW_ACC]),
            .in_valid  (in_vld_q),
            .in_last   (in_last_q),
            .sum       (tree_sum[g]),
            .out_valid (),
            .out_last  ()
         );
      end
   end

   // Accumulate and output-buffer stage
   always_comb begin
      acc_d       = acc_q;
      beats_d     = beats_q;
      first_d     = first_q;
      out_c_d     = out_c_q;
      out_beats_d = out_beats_q;
      out_valid_d = out_valid_q & ~out_ready;
      beats_new   = first_q ? 8'd1 : sat_inc(beats_q);
      for (int o = 0; o < N_OUT; o++) begin
         sum_new[o] = (first_q ? DW_ACC'(0) : acc_q[o]) + tree_sum[o];
      end
      if (tree_vld && !stall) begin
         if (tree_last) begin
            for (int o = 0; o < N_OUT; o++) out_c_d[o*DW_ACC +: DW_ACC] = sum_new[o];
            out_beats_d = beats_new;
            out_valid_d = 1'b1;
            first_d     = 1'b1;
         end else begin
            acc_d   = sum_new;
            beats_d = beats_new;
            first_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int o = 0; o < N_OUT; o++) acc_q[o] <= '0;
         beats_q     <= '0;
         first_q     <= 1'b1;
         out_c_q     <= '0;
         out_beats_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         beats_q     <= beats_d;
         first_q     <= first_d;
         out_c_q     <= out_c_d;
         out_beats_q <= out_beats_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_c     = out_c_q;
   assign out_beats = out_beats_q;
   assign out_valid = out_valid_q;

endmodule
